// File: rtl/inst_sram_axi_bridge_pkg.sv
// rtl/inst_sram_axi_bridge_pkg.sv - shared AR state encodings and AXI constants for the fetch bridge
// Purpose: one home for the AR-channel FSM encoding, the fixed AXI field values
//          and the outstanding-counter width used across the bridge.
// Ports:   none (package).
package inst_sram_axi_bridge_pkg;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] SIZE_4B    = 3'b010;

  // Wide enough to hold the largest supported limit of four in-flight fetches.
  localparam int CNT_W = 3;

endpackage

// File: rtl/inst_sram_axi_bridge_if.sv
// rtl/inst_sram_axi_bridge_if.sv - requester-side and AXI read-channel interfaces for the fetch bridge
// Purpose: inst_sram_if groups the req/addr_ok/data_ok fetch port; axi_rd_if groups
//          the AXI AR and R channels. master drives the request, slave responds.
// Ports:   inst_sram_if: req, wr, size, wstrb, addr, wdata -> ; <- addr_ok, data_ok, rdata
//          (+ inst_sram_err when INST_BRIDGE_RESP_ERR_EN is defined).
//          axi_rd_if: ar* and rready from master; arready and r* from slave.
// Config:  INST_BRIDGE_RESP_ERR_EN adds inst_sram_err to inst_sram_if.
interface inst_sram_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [2:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
`ifdef INST_BRIDGE_RESP_ERR_EN
  logic        inst_sram_err;

  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, inst_sram_err
  );
  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, inst_sram_err
  );
`else
  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );
  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );
`endif
endinterface

interface axi_rd_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/inst_sram_axi_bridge_outstanding_cnt.sv
// rtl/inst_sram_axi_bridge_outstanding_cnt.sv - accepted-but-unreturned fetch counter
// Purpose: counts fetches accepted on the requester side that have not yet
//          returned data; full stops further acceptance.
// Ports:   clk, reset (sync, active-high); inc (acceptance); dec (data returned);
//          count (current in-flight total); full (count reached MAX_OUTSTANDING).
module bridge_outstanding_cnt
  import inst_sram_axi_bridge_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  // inc and dec together leave the total unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc) begin
      count <= count - CNT_W'(1);
    end
  end

  assign full = (count >= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: rtl/inst_sram_axi_bridge.sv
// rtl/inst_sram_axi_bridge.sv - instruction-fetch req/addr_ok/data_ok to single-beat AXI read bridge
// Purpose: accepts fetch requests, issues one single-beat AXI read per request,
//          and returns read data in order with no added latency.
// Ports:   clk, reset (sync, active-high);
//          sram (inst_sram_if.slave): requester-side fetch port;
//          axi  (axi_rd_if.master):   AXI AR and R channels.
// Params:  MAX_OUTSTANDING (1..4) in-flight limit; AR_ID constant arid.
// Config:  INST_BRIDGE_RESP_ERR_EN - non-OKAY rresp zeroes rdata and pulses inst_sram_err.
module inst_sram_axi_bridge
  import inst_sram_axi_bridge_pkg::*;
#(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] AR_ID           = 4'd0
) (
  input logic        clk,
  input logic        reset,
  inst_sram_if.slave sram,
  axi_rd_if.master   axi
);

  ar_state_t        state;
  ar_state_t        state_nxt;
  logic [31:0]      addr_q;
  logic [2:0]       size_q;
  logic             addr_ok;
  logic             accept;
  logic             data_ok;
  logic             cnt_full;
  logic [CNT_W-1:0] count;

  // Only one AR may be pending; a new request waits until the current one is taken.
  assign addr_ok = (state == AR_IDLE) && !cnt_full;
  assign accept  = sram.inst_sram_req && addr_ok;
  assign data_ok = axi.rvalid && axi.rready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= AR_IDLE;
      addr_q <= '0;
      size_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q <= sram.inst_sram_addr;
        size_q <= sram.inst_sram_size;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      AR_IDLE: if (accept) state_nxt = AR_SEND;
      AR_SEND: if (axi.arready) state_nxt = AR_IDLE;
      default: state_nxt = AR_IDLE;
    endcase
  end

  bridge_outstanding_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (accept),
    .dec  (data_ok),
    .count(count),
    .full (cnt_full)
  );

  assign axi.arid    = AR_ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = size_q;
  assign axi.arburst = BURST_INCR;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = (state == AR_SEND);

  // Beats arriving with nothing in flight are left unacknowledged.
  assign axi.rready = (count != '0);

  assign sram.inst_sram_addr_ok = addr_ok;
  assign sram.inst_sram_data_ok = data_ok;

`ifdef INST_BRIDGE_RESP_ERR_EN
  logic resp_err;
  assign resp_err              = data_ok && (axi.rresp != RESP_OKAY);
  assign sram.inst_sram_rdata  = resp_err ? 32'h0 : axi.rdata;
  assign sram.inst_sram_err    = resp_err;

  // Fetches are always reads, so write fields and single-beat framing are not needed.
  logic unused_inputs;
  assign unused_inputs = ^{sram.inst_sram_wr, sram.inst_sram_wstrb, sram.inst_sram_wdata,
                           axi.rid, axi.rlast};
`else
  assign sram.inst_sram_rdata = axi.rdata;

  logic unused_inputs;
  assign unused_inputs = ^{sram.inst_sram_wr, sram.inst_sram_wstrb, sram.inst_sram_wdata,
                           axi.rid, axi.rlast, axi.rresp};
`endif

endmodule
